// File: rtl/fpu_pkg.sv
// Shared FPU definitions: GRS default, width derivations and add/sub op encoding.
package fpu_pkg;

  localparam int unsigned GRS_W_DEF = 3;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // Adder width: carry bit + large fraction + guard/round/sticky.
  function automatic int unsigned cal_w(input int unsigned frac_w, input int unsigned grs_w);
    return frac_w + grs_w + 1;
  endfunction

  // Count width able to represent 0..w inclusive.
  function automatic int unsigned lzc_w(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/fadd_lzc.sv
// Leading-zero counter; returns W when the input is all zeros.
module fadd_lzc
  import fpu_pkg::*;
#(
  parameter int unsigned W = 28,
  localparam int unsigned OW = lzc_w(W)
) (
  input  logic [W-1:0]  d,
  output logic [OW-1:0] cnt_c
);

  // Later (higher) set bits overwrite earlier ones, leaving the MSB's distance.
  always_comb begin
    cnt_c = OW'(W);
    for (int i = 0; i < int'(W); i++) begin
      if (d[i]) cnt_c = OW'(int'(W) - 1 - i);
    end
  end

endmodule

// File: rtl/fadd_cal_pipe.sv
// Two-stage fraction add/sub with zero flag and optional leading-zero count.
// Define FADD_CAL_PIPE_LZC_EN to compute lzc; otherwise lzc is tied to 0.
module fadd_cal_pipe
  import fpu_pkg::*;
#(
  parameter int unsigned FRAC_W = 24,
  parameter int unsigned GRS_W  = GRS_W_DEF,
  parameter int unsigned TAG_W  = 9,
  localparam int unsigned CAL_W = cal_w(FRAC_W, GRS_W),
  localparam int unsigned LZC_W = lzc_w(CAL_W)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    op_sub,
  input  logic [FRAC_W-1:0]       large_frac,
  input  logic [FRAC_W+GRS_W-1:0] small_frac,
  input  logic [TAG_W-1:0]        in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CAL_W-1:0]        cal_frac,
  output logic                    frac_zero,
  output logic [LZC_W-1:0]        lzc,
  output logic [TAG_W-1:0]        out_tag
);

  logic                    s1_v;
  op_e                     s1_op;
  logic [FRAC_W-1:0]       s1_large;
  logic [FRAC_W+GRS_W-1:0] s1_small;
  logic [TAG_W-1:0]        s1_tag;
  logic                    s2_v;
  logic                    s2_adv;
  logic [CAL_W-1:0]        ext_large;
  logic [CAL_W-1:0]        ext_small;
  logic [CAL_W-1:0]        sum_c;

  assign s2_adv    = !s2_v || out_ready;
  assign in_ready  = !s1_v || s2_adv;
  assign out_valid = s2_v;

  // Stage 1: capture operands; holds while stage 2 is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v     <= 1'b0;
      s1_op    <= OP_ADD;
      s1_large <= '0;
      s1_small <= '0;
      s1_tag   <= '0;
    end else if (in_ready) begin
      s1_v <= in_valid;
      if (in_valid) begin
        s1_op    <= op_e'(op_sub);
        s1_large <= large_frac;
        s1_small <= small_frac;
        s1_tag   <= in_tag;
      end
    end
  end

  // Result wraps modulo 2^CAL_W; operand ordering is the caller's job.
  always_comb begin
    ext_large = {1'b0, s1_large, GRS_W'(0)};
    ext_small = {1'b0, s1_small};
    sum_c     = (s1_op == OP_SUB) ? (ext_large - ext_small) : (ext_large + ext_small);
  end

  // Stage 2: result register, held while downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_v      <= 1'b0;
      cal_frac  <= '0;
      frac_zero <= 1'b0;
      out_tag   <= '0;
    end else if (s2_adv) begin
      s2_v <= s1_v;
      if (s1_v) begin
        cal_frac  <= sum_c;
        frac_zero <= (sum_c == '0);
        out_tag   <= s1_tag;
      end
    end
  end

`ifdef FADD_CAL_PIPE_LZC_EN
  logic [LZC_W-1:0] lzc_c;

  fadd_lzc #(.W(CAL_W)) u_lzc (
    .d     (sum_c),
    .cnt_c (lzc_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      lzc <= '0;
    end else if (s2_adv && s1_v) begin
      lzc <= lzc_c;
    end
  end
`else
  assign lzc = '0;
`endif

endmodule

// File: doc/fadd_cal_pipe.md
FADD_CAL_PIPE -- requirements
Module: fadd_cal_pipe

Interface
REQ-001 SHALL have parameter FRAC_W, default 24, giving the large-operand fraction width including the hidden bit (53 for double).
REQ-002 SHALL have parameter GRS_W, default 3, giving the guard/round/sticky bits appended to the small operand.
REQ-003 SHALL have parameter TAG_W, default 9, giving the width of the sideband tag (sign/exponent) carried alongside the data.
REQ-004 SHALL use localparams CAL_W = FRAC_W+GRS_W+1 and LZC_W = clog2(CAL_W+1).
REQ-005 SHALL have one clock and a synchronous, active-high reset, with ports named as follows.
REQ-006 clk  in  1  sole clock; all state updates on its rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 in_valid  in  1  input operands present.
REQ-009 in_ready  out  1  block accepts the input this cycle.
REQ-010 op_sub  in  1  1 = subtract, 0 = add.
REQ-011 large_frac  in  FRAC_W  aligned larger fraction.
REQ-012 small_frac  in  FRAC_W+GRS_W  shifted smaller fraction with GRS bits.
REQ-013 in_tag  in  TAG_W  sideband, passed through unchanged.
REQ-014 out_valid  out  1  result present.
REQ-015 out_ready  in  1  downstream accepts the result.
REQ-016 cal_frac  out  CAL_W  sum or difference.
REQ-017 frac_zero  out  1  cal_frac is all zeros.
REQ-018 lzc  out  LZC_W  leading-zero count of cal_frac.
REQ-019 out_tag  out  TAG_W  tag of the result.

Function
REQ-020 SHALL compute cal_frac = {0,large_frac,GRS_W zeros} + or - {0,small_frac}, modulo 2^CAL_W.
REQ-021 SHALL produce a wrapped result without any flag when large < small; ordering is the caller's duty.
REQ-022 SHALL be a two-stage pipeline: S1 registers the operands, op_sub and the tag; S2 registers cal_frac, frac_zero, lzc and the tag.
REQ-023 SHALL have a latency of 2 cycles from input handshake to out_valid when there is no stall.
REQ-024 SHALL sustain a throughput of 1 result per cycle while out_ready=1.
REQ-025 SHALL set in_ready = !s1_v || s2_adv, where s2_adv = !s2_v || out_ready; in_ready has no combinational path from in_valid.
REQ-026 SHALL transfer on in_valid && in_ready, and on out_valid && out_ready.
REQ-027 SHALL hold cal_frac, flags and out_tag stable while out_valid=1 && out_ready=0.
REQ-028 SHALL never drop, duplicate or reorder an accepted operand set.
REQ-029 SHALL handle a simultaneous input accept and output accept in the same cycle by advancing both stages with no bubble.
REQ-030 SHALL set lzc to the number of zeros above the most significant 1 of cal_frac, and to CAL_W when cal_frac is zero.

Reset
REQ-031 SHALL, on rst, clear s1_v and s2_v, so that out_valid=0 in the next cycle.
REQ-032 SHALL reset cal_frac, lzc, out_tag and frac_zero to 0.
REQ-033 SHALL discard in-flight data when reset is asserted mid-operation.
REQ-034 SHALL drive in_ready=1 on the first cycle after rst deasserts.

Configuration
REQ-035 SHALL compute lzc in S2 when FADD_CAL_PIPE_LZC_EN is defined.
REQ-036 SHALL, when FADD_CAL_PIPE_LZC_EN is undefined, drive lzc constant 0, keep the port, and synthesise no lzc logic; frac_zero is unaffected.

Structure
REQ-037 SHALL keep the GRS_W default, the CAL_W/LZC_W derivation functions and the op encoding (OP_ADD=0, OP_SUB=1) in the shared package fpu_pkg.
REQ-038 SHALL place the leading-zero counter in sub-module fadd_lzc, parametrised by width.

Verification
REQ-039 SHALL check, with FRAC_W=24: add, large=0x800000, small=0x4000000 -> cal_frac=0x8000000, lzc=0, frac_zero=0, 2 cycles after accept.
REQ-040 SHALL check: sub, large=0x800000, small=0x4000000 -> cal_frac=0, frac_zero=1, lzc=28.
REQ-041 SHALL check: sub, large=0x800000, small=0x0000001 -> cal_frac=0x3FFFFFF, lzc=2, out_tag equal to in_tag.
REQ-042 SHALL check: 5 back-to-back inputs with out_ready=0 for 3 cycles -> in_ready=0 after 2 accepts, then all 5 results delivered in order with none lost.
REQ-043 SHALL check: rst asserted while both stages are valid -> out_valid=0 next cycle, in_ready=1 after release, and no stale result appears.
REQ-044 SHALL check: build without FADD_CAL_PIPE_LZC_EN -> lzc=0 for all vectors, while cal_frac and frac_zero are unchanged.
